aqp_handctrl_sched: RTL
=======================

# aqp_handctrl_sched

Scan scheduler and controller for the two daisy-chained hand-controller shift registers (16 bits total, 8 per controller). It sequences the parallel-load / serial-shift protocol on the external chain, runs periodic or on-demand scans, optionally debounces results, and publishes stable controller bytes plus a change interrupt to the I/O register block.

## Interface
Parameters:
- CLK_DIV, 128: clk cycles per hctrl_clk half-period; legal range 2..255.
- SCAN_GAP, 1024: idle clk cycles between the end of one scan and the start of the next in periodic mode; legal range 1..65535.
- DEBOUNCE, 2: number of consecutive identical scans required before an update; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hctrl_clk  out  1  shift clock to the external chain; the chain shifts on the rising edge.
- hctrl_load_n  out  1  active-low parallel load to the external chain.
- hctrl_data  in  1  serial data from the chain.
- scan_en  in  1  level; enables periodic scanning.
- scan_now  in  1  one-cycle request for a single scan; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- hctrl1_data  out  8  published controller 1 byte.
- hctrl2_data  out  8  published controller 2 byte.
- changed  out  1  one-cycle pulse when the published bytes change.
- irq  out  1  sticky change interrupt.
- irq_ack  in  1  clears irq.

## Operation
- States: IDLE, LOAD, SHIFT, COMMIT, GAP.
- IDLE: hctrl_clk=0, hctrl_load_n=1. Go to LOAD if scan_en=1 or scan_now=1.
- LOAD: hctrl_load_n=0 and hctrl_clk=0 for 2*CLK_DIV cycles, then SHIFT with bit counter=0.
- SHIFT: 16 bit periods of 2*CLK_DIV cycles each. hctrl_clk is low for the first CLK_DIV cycles and high for the second. hctrl_data is sampled on the last low cycle. The sample shifts into the LSB of a 16-bit register, so the first sampled bit ends in bit 15. After bit 15's high phase, the FSM goes to COMMIT.
- COMMIT, one cycle: hctrl1_data candidate = sample[7:0]; hctrl2_data candidate = sample[15:8]. Apply the debounce rule (see Configuration). If the published value changes, update hctrl1_data and hctrl2_data, pulse changed, and set irq on the same edge. Next state is GAP if scan_en=1, else IDLE.
- GAP: count SCAN_GAP cycles, then LOAD if scan_en=1, else IDLE. scan_now is ignored outside IDLE.
- Deasserting scan_en mid-scan does not abort the scan: it completes through COMMIT, then goes to IDLE.
- irq: set on change and cleared by irq_ack. If set and ack occur in the same cycle, set wins.
- Counters:
  - Phase counter width is $clog2(2*CLK_DIV).
  - Gap counter is 16 bits.
  - Bit counter is 4 bits and must not wrap into a 17th bit.
  - Debounce counter is 4 bits and saturates at DEBOUNCE.

## Timing
- Scan length, LOAD entry to COMMIT inclusive: 2*CLK_DIV + 32*CLK_DIV + 1 cycles. With defaults this is 4353 cycles.
- Periodic period: scan length + SCAN_GAP. With defaults this is 5377 cycles.
- scan_now in IDLE: LOAD starts the next cycle, and busy rises the next cycle.
- Outputs update on the clk edge that ends COMMIT. changed is high for exactly the following cycle.
- Reset, including mid-scan: state=IDLE, hctrl_clk=0, hctrl_load_n=1, hctrl1_data=hctrl2_data=8'hFF, changed=0, irq=0, busy=0, shift register=16'hFFFF, debounce count=0.

## Configuration
- AQP_HANDCTRL_DEBOUNCE_EN defined:
  - COMMIT compares the sample against the previous scan's sample.
  - On a match the count increments; on a mismatch it resets to 1.
  - The published value updates only when the count reaches DEBOUNCE and the sample differs from the published value.
  - After reset, the first scan counts as 1.
- Not defined: every COMMIT publishes its sample directly. DEBOUNCE is unused and no debounce state is synthesised.

## Test plan
- Reset with no stimulus -> hctrl1_data=hctrl2_data=8'hFF, hctrl_load_n=1, hctrl_clk=0, busy=0, irq=0.
- scan_now pulse, CLK_DIV=4, chain preset 16'hA55A, first bit = bit 15 -> hctrl_load_n low for 8 cycles. Then 16 clock periods of 8 cycles. Then hctrl2_data=8'hA5, hctrl1_data=8'h5A. Debounce disabled: changed pulses once and irq=1, 137 cycles after LOAD entry.
- AQP_HANDCTRL_DEBOUNCE_EN, DEBOUNCE=3, periodic mode:
  - Chain 16'h00FE for 2 scans, then 16'h01FE -> no update.
  - Chain 16'h01FE for 3 scans -> update on the 3rd COMMIT only.
- scan_en=1 with SCAN_GAP=10 and constant data -> LOAD entries exactly scan length + 10 cycles apart; no changed pulses after the first.
- irq_ack asserted in the same cycle as a new change -> irq stays 1. A later irq_ack alone -> irq=0.
- reset asserted during SHIFT bit 7 -> next cycle: IDLE, hctrl_load_n=1, outputs 8'hFF. A subsequent scan_now completes a full 16-bit scan.

Source files
------------

// File: rtl/aqp_handctrl_sched_if.sv
// aqp_handctrl_sched_if: hand-controller chain pins, scan control
// and published-result signals of the scan scheduler.
interface aqp_handctrl_sched_if;
  logic       hctrl_clk;
  logic       hctrl_load_n;
  logic       hctrl_data;
  logic       scan_en;
  logic       scan_now;
  logic       busy;
  logic [7:0] hctrl1_data;
  logic [7:0] hctrl2_data;
  logic       changed;
  logic       irq;
  logic       irq_ack;

  modport master (
    output scan_en, scan_now, irq_ack, hctrl_data,
    input  hctrl_clk, hctrl_load_n, busy,
    input  hctrl1_data, hctrl2_data, changed, irq
  );

  modport slave (
    input  scan_en, scan_now, irq_ack, hctrl_data,
    output hctrl_clk, hctrl_load_n, busy,
    output hctrl1_data, hctrl2_data, changed, irq
  );
endinterface

// File: rtl/aqp_handctrl_sched.sv
// aqp_handctrl_sched: load/shift scan of two daisy-chained pads.
// Optional debounce: define AQP_HANDCTRL_DEBOUNCE_EN.
module aqp_handctrl_sched #(
  parameter int CLK_DIV  = 128,
  parameter int SCAN_GAP = 1024,
  parameter int DEBOUNCE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  aqp_handctrl_sched_if.slave   p
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_MID  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [15:0]   GAP_LAST = 16'(SCAN_GAP - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255 ||
      SCAN_GAP < 1 || SCAN_GAP > 65535 ||
      DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_param
    $error("aqp_handctrl_sched: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [PW-1:0] ph_q;
  logic [3:0]    bit_q;
  logic [15:0]   gap_q;
  logic [15:0]   sample_q;
  logic [15:0]   pub_q;
  logic          hclk_q;
  logic          load_n_q;
  logic          busy_q;
  logic          changed_q;
  logic          irq_q;
  logic          pub_upd;

`ifdef AQP_HANDCTRL_DEBOUNCE_EN
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [15:0] prev_q;
  logic [3:0]  dbc_q;
  logic [3:0]  dbc_d;

  // Count consecutive identical scans; zero only after reset.
  always_comb begin
    dbc_d = 4'd1;
    if (dbc_q != 4'd0 && sample_q == prev_q) begin
      dbc_d = (dbc_q >= DB) ? DB : dbc_q + 4'd1;
    end
    pub_upd = (dbc_d == DB) && (sample_q != pub_q);
  end

  // Debounce history advances once per scan, at COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 16'hFFFF;
      dbc_q  <= 4'd0;
    end else if (state_q == S_COMMIT) begin
      prev_q <= sample_q;
      dbc_q  <= dbc_d;
    end
  end
`else
  // Every scan publishes directly when it differs.
  always_comb begin
    pub_upd = (sample_q != pub_q);
  end
`endif

  // Scan FSM with registered chain pins and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      bit_q     <= 4'd0;
      gap_q     <= 16'd0;
      sample_q  <= 16'hFFFF;
      pub_q     <= 16'hFFFF;
      hclk_q    <= 1'b0;
      load_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      changed_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (p.irq_ack) irq_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (p.scan_en || p.scan_now) begin
            state_q  <= S_LOAD;
            ph_q     <= '0;
            load_n_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ph_q == PH_LAST) begin
            state_q  <= S_SHIFT;
            ph_q     <= '0;
            bit_q    <= 4'd0;
            load_n_q <= 1'b1;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_SHIFT: begin
          ph_q <= ph_q + 1'b1;
          if (ph_q == PH_MID) begin
            sample_q <= {sample_q[14:0], p.hctrl_data};
            hclk_q   <= 1'b1;
          end
          if (ph_q == PH_LAST) begin
            ph_q   <= '0;
            hclk_q <= 1'b0;
            if (bit_q == 4'd15) begin
              state_q <= S_COMMIT;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_COMMIT: begin
          if (pub_upd) begin
            pub_q     <= sample_q;
            changed_q <= 1'b1;
            irq_q     <= 1'b1;
          end
          if (p.scan_en) begin
            state_q <= S_GAP;
            gap_q   <= 16'd0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (p.scan_en) begin
              state_q  <= S_LOAD;
              ph_q     <= '0;
              load_n_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          hclk_q   <= 1'b0;
          load_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign p.hctrl_clk    = hclk_q;
  assign p.hctrl_load_n = load_n_q;
  assign p.busy         = busy_q;
  assign p.hctrl1_data  = pub_q[7:0];
  assign p.hctrl2_data  = pub_q[15:8];
  assign p.changed      = changed_q;
  assign p.irq          = irq_q;

endmodule
